instr_mem_loader: RTL and testbench

// - Boot-time writer for the CPU's read-only instruction memory; the write side of the instruction fetch port.
// - Accepts a byte stream (valid/ready), assembles little-endian 32-bit words and issues one write per word at successive word addresses.
// - Holds the CPU in reset until a complete, valid image has been written.
// - Sits between the host/UART byte source and the instruction memory write port.

---
 rtl/loader_pkg.sv | 10 +
 rtl/byte_assembler.sv | 41 ++++
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
// The CHK state is only reachable when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    typedef enum logic [2:0] {LEN0, LEN1, DATA, CHK, DONE, ERR} loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid pulses for one cycle, the cycle after the 4th byte of a word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        clear,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [31:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            sr         <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
                sr  <= '0;
            end else if (byte_valid) begin
                // Shift in from the top so the first byte ends up in [7:0]
                sr  <= {byte_in, sr[31:8]};
                cnt <= cnt + 2'd1;
                if (cnt == 2'(BYTES_PER_WORD - 1)) begin
                    word_out   <= {byte_in, sr[31:8]};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time loader: length-prefixed byte stream -> instruction memory writes,
// holding the CPU in reset until the image is in. Optional LOADER_CHECKSUM_EN.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int          IDX_W = ADDR_WIDTH - 2;
    localparam logic [16:0] CAP   = 17'(1) << IDX_W;

    loader_state_t    state;
    logic [7:0]       len_lo;
    logic [15:0]      len_m1;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_pos;
    logic             accept;
    logic [15:0]      len_word;
    logic             last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum;
    logic [7:0]       chk_total;
    assign chk_total = sum + rx_data;
`endif

    assign rx_ready  = !reset && (state == LEN0 || state == LEN1 || state == DATA
`ifdef LOADER_CHECKSUM_EN
                                  || state == CHK
`endif
                                 );
    assign accept    = rx_valid && rx_ready;
    assign len_word  = {rx_data, len_lo};
    assign last_byte = (byte_pos == 2'(BYTES_PER_WORD - 1));

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (rx_data),
        .byte_valid (accept && state == DATA),
        .clear      (state != DATA),
        .word_out   (wr_data),
        .word_valid (wr_en)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LEN0;
            len_lo    <= '0;
            len_m1    <= '0;
            word_idx  <= '0;
            byte_pos  <= '0;
            wr_addr   <= '0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            // Lags DONE by one cycle so the final write lands before the CPU runs
            cpu_reset <= (state != DONE);
            if (accept) begin
                unique case (state)
                    LEN0: begin
                        len_lo <= rx_data;
                        state  <= LEN1;
                    end
                    LEN1: begin
                        word_idx <= '0;
                        byte_pos <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                        if (len_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            load_done <= 1'b1;
`endif
                        end else if ({1'b0, len_word} > CAP) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else begin
                            len_m1 <= len_word - 16'd1;
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        byte_pos <= byte_pos + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum + rx_data;
`endif
                        if (last_byte) begin
                            wr_addr  <= {word_idx, 2'b00};
                            word_idx <= word_idx + 1'b1;
                            if (16'(word_idx) == len_m1) begin
`ifdef LOADER_CHECKSUM_EN
                                state     <= CHK;
`else
                                state     <= DONE;
                                load_done <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHK: begin
                        if (chk_total == 8'd0) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; memory writes are checked against a
// queue of expected {addr,data} pairs filled as the image bytes are sent.
module tb_instr_mem_loader;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_reset;
    logic          load_done;
    logic          load_err;

    int            n_vec = 0;
    int            n_err = 0;
    int            wr_cnt = 0;
    logic [43:0]   exp_q[$];

    instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any write issued this cycle
    task automatic tick();
        logic [43:0] e;
        @(negedge clk);
        if (wr_en === 1'b1) begin
            wr_cnt++;
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr_data", 64'({wr_addr, wr_data}), 64'(e));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    // Offer a byte for one cycle without waiting for rx_ready
    task automatic offer_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        chk("rst_wr_en",     64'(wr_en),     64'd0);
        chk("rst_wr_addr",   64'(wr_addr),   64'd0);
        chk("rst_wr_data",   64'(wr_data),   64'd0);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_load_err",  64'(load_err),  64'd0);
        chk("rst_rx_ready",  64'(rx_ready),  64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);
    endtask

    task automatic load_image(input logic [31:0] words[$], input int gap_max);
        logic [15:0] n;
        logic [7:0]  s;
        logic [31:0] w;
        n = 16'(words.size());
        s = 8'd0;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            exp_q.push_back({12'(i * 4), w});
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, gap_max)) tick();
                s = s + w[7:0];
                send_byte(w[7:0]);
                w = w >> 8;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'd0 - s);
`endif
    endtask

    initial begin
        logic [31:0] img[$];
        int          base;

        do_reset();

        // Two-word image, back to back
        img = '{32'h00100513, 32'h00200593};
        load_image(img, 0);
        chk("n2_load_done",  64'(load_done), 64'd1);
        chk("n2_rx_ready",   64'(rx_ready),  64'd0);
        chk("n2_cpu_rst_hold", 64'(cpu_reset), 64'd1);
        tick();
        chk("n2_cpu_release", 64'(cpu_reset), 64'd0);
        chk("n2_load_err",    64'(load_err),  64'd0);
        chk("n2_sb_empty",    64'(exp_q.size()), 64'd0);

        // Empty image
        do_reset();
        base = wr_cnt;
        send_byte(8'h00);
        chk("n0_not_done_early", 64'(load_done), 64'd0);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        chk("n0_load_done", 64'(load_done), 64'd1);
        chk("n0_rx_ready",  64'(rx_ready),  64'd0);
        offer_byte(8'h55);
        tick();
        chk("n0_refused_state", 64'({load_done, load_err}), 64'b10);
        chk("n0_no_writes",     64'(wr_cnt - base), 64'd0);

        // Oversize image: 0x401 words > 1024
        do_reset();
        base = wr_cnt;
        send_byte(8'h01);
        send_byte(8'h04);
        chk("big_load_err",  64'(load_err),  64'd1);
        chk("big_load_done", 64'(load_done), 64'd0);
        chk("big_rx_ready",  64'(rx_ready),  64'd0);
        repeat (5) tick();
        chk("big_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("big_no_writes", 64'(wr_cnt - base), 64'd0);

        // Reset after 6 payload bytes of a 4-word load, then a fresh 1-word load
        do_reset();
        send_byte(8'h04);
        send_byte(8'h00);
        exp_q.push_back({12'h000, 32'h44332211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        do_reset();
        base = wr_cnt;
        img = '{32'hDEADBEEF};
        load_image(img, 0);
        tick();
        chk("mid_rst_writes",    64'(wr_cnt - base), 64'd1);
        chk("mid_rst_load_done", 64'(load_done), 64'd1);
        chk("mid_rst_sb_empty",  64'(exp_q.size()), 64'd0);

        // Three words with random rx_valid gaps
        do_reset();
        base = wr_cnt;
        img = '{$urandom, $urandom, $urandom};
        load_image(img, 3);
        tick();
        chk("gap_writes",    64'(wr_cnt - base), 64'd3);
        chk("gap_load_done", 64'(load_done), 64'd1);
        chk("gap_sb_empty",  64'(exp_q.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum
        do_reset();
        exp_q.push_back({12'h000, 32'h01020304});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'hF6);
        tick();
        chk("cs_ok_done", 64'({load_done, load_err}), 64'b10);
        chk("cs_ok_cpu",  64'(cpu_reset), 64'd0);
        // Bad checksum
        do_reset();
        exp_q.push_back({12'h000, 32'h01020304});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'hF7);
        tick();
        chk("cs_bad_err", 64'({load_done, load_err}), 64'b01);
        chk("cs_bad_cpu", 64'(cpu_reset), 64'd1);
        chk("cs_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
